spi_cfg_regs: RTL and testbench
===============================

# spi_cfg_regs

Command/register stage directly downstream of the SPI byte deserializer, clocked on SCLK. It parses the deserialized byte stream into framed register transactions (command byte, then data bytes with address auto-increment) and holds the 16-entry configuration register file. The file drives the demoscene configuration outputs (background_state, solid_color, audio_en) and supplies read-back bytes to the MISO shifter.

## Interface
- ADDR_W, 4: register address width (16 registers)
- BG_RESET, 8'd10: reset value of background_state
- SCLK input 1: SPI clock; all logic on posedge
- rst_n input 1: reset, synchronous, active-low; clock SCLK
- SSEL input 1: chip select, high = deselected; aborts the frame
- byte_valid input 1: one-cycle pulse; byte_data holds a complete received byte
- byte_data input 8: received byte, MSB first on the wire
- tx_byte output 8: next byte for the MISO shifter; stable between byte_valid pulses
- background_state output 8: register 0
- solid_color output 6: register 1 [5:0]
- audio_en output 1: register 2 [0]
- wr_strobe output 1: one-cycle pulse on each committed write
- wr_addr output ADDR_W: address of the write flagged by wr_strobe

## Operation
- Register map:
  - 0 background_state (8b).
  - 1 solid_color (6b; bits 7:6 read 0).
  - 2 audio_en (1b; bits 7:1 read 0).
  - 3 scratch (8b).
  - 4–14 reserved: read 0, writes ignored, no wr_strobe.
  - 15 status, read-only: {err_cnt[3:0], frame_cnt[3:0]}.
- Command byte: bit7 = 1 read / 0 write; bits6:4 must be 000; bits3:0 start address.
- FSM states: IDLE, WRITE, READ, ERR.
  - IDLE + byte_valid: bits6:4 ≠ 0 → ERR, err_cnt += 1 (saturates at 15). Otherwise → READ or WRITE, addr ← bits3:0, frame_cnt += 1 (wraps 15→0).
  - WRITE + byte_valid: store to addr if writable, pulse wr_strobe/wr_addr, addr ← addr+1.
  - READ + byte_valid: the data byte is a don't-care; addr ← addr+1.
  - ERR: ignores all bytes until SSEL.
- Address wraps 15→0 in WRITE and READ.
- Writes to 15 or 4–14 advance addr, no strobe.
- SSEL high on a posedge → IDLE, addr cleared. Committed writes persist; a partial byte is never written.
- tx_byte:
  - 0x00 in IDLE, WRITE and ERR.
  - In READ: read value of the current addr, prefetched.

## Timing
- Reset (rst_n low at posedge) values:
  - background_state = BG_RESET; solid_color = 0; audio_en = 0.
  - scratch = 0; err_cnt = 0; frame_cnt = 0.
  - FSM IDLE; addr = 0; tx_byte = 0x00; wr_strobe = 0; wr_addr = 0.
- rst_n has priority over SSEL and byte_valid.
- Write latency: byte_valid at edge N → register and outputs updated, wr_strobe high, after edge N+1 (registered). wr_strobe is low on every other cycle.
- Read prefetch: command byte_valid at edge N → tx_byte = reg[start] after edge N+1. Each further byte_valid at edge M → tx_byte = reg[addr+1] after edge M+1. This leaves ≥6 SCLK edges before the shifter loads it.
- Reading status returns the value after the current command's frame_cnt increment.
- byte_valid and SSEL high on the same edge: SSEL wins; the byte is discarded.
- The deserializer guarantees byte_valid pulses are ≥8 cycles apart. Behaviour on back-to-back pulses is still defined: each is processed in order, one per cycle.
- SCLK only runs during transfers. SSEL is therefore effective only at the first edge of the next frame, and the FSM must accept a command byte in that same frame.

## Structure
- Shared package holds:
  - Register address constants (REG_BG=0, REG_COLOR=1, REG_AUDIO=2, REG_SCRATCH=3, REG_STATUS=15).
  - Command field positions (CMD_RD_BIT=7, CMD_RSVD=6:4).
  - The FSM state enum.
- One natural sub-module: spi_cfg_regfile, containing:
  - Write decode with writable-mask.
  - Read mux with zero-fill for narrow/reserved registers.
  - Status counters.
- The FSM, address counter and tx prefetch stay in the top.

## Test plan
- Reset, then SSEL low, bytes 0x00, 0x2A, 0x15, 0x01, SSEL high:
  - background_state=0x2A, solid_color=0x15, audio_en=1.
  - Three wr_strobe pulses, addresses 0, 1, 2.
- Read from 0x8F after one good frame and one ERR frame: tx_byte=0x12 (err 1, frame 2 including this one), then register 0 value on the next byte.
- Write burst 0x0F, 0xAA, 0x55:
  - Status unchanged, no strobe for 0xAA.
  - Address wraps; background_state=0x55, wr_addr=0.
- Command 0x30, then 0xFF, 0xFF: no register change, no wr_strobe, err_cnt+1. Next frame 0x03, 0x77 → scratch=0x77.
- SSEL high mid-write-burst after 0x00, 0x11 (and 4 bits of the next byte):
  - background_state=0x11, solid_color unchanged.
  - Next frame starts in IDLE.
- rst_n low mid-read-frame: all outputs return to reset values, including background_state=10. The FSM parses the following byte as a command.

Source files
------------

// File: rtl/spi_cfg_regs_pkg.sv
// spi_cfg_regs_pkg: shared register map, command fields and FSM states
package spi_cfg_regs_pkg;
    localparam logic [3:0] REG_BG      = 4'd0;
    localparam logic [3:0] REG_COLOR   = 4'd1;
    localparam logic [3:0] REG_AUDIO   = 4'd2;
    localparam logic [3:0] REG_SCRATCH = 4'd3;
    localparam logic [3:0] REG_STATUS  = 4'd15;
    localparam int CMD_RD_BIT  = 7;
    localparam int CMD_RSVD_HI = 6;
    localparam int CMD_RSVD_LO = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_ERR} state_t;
    function automatic logic cmd_bad(input logic [7:0] b);
        return b[CMD_RSVD_HI:CMD_RSVD_LO] != 3'b000;
    endfunction
endpackage

// File: rtl/spi_cfg_regs_if.sv
// spi_cfg_regs_if: byte stream in, config outputs and MISO byte out
interface spi_cfg_regs_if #(parameter int ADDR_W = 4) ();
    logic              SSEL;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic [7:0]        tx_byte;
    logic [7:0]        background_state;
    logic [5:0]        solid_color;
    logic              audio_en;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    modport master (
        output SSEL, byte_valid, byte_data,
        input  tx_byte, background_state, solid_color, audio_en, wr_strobe, wr_addr
    );
    modport slave (
        input  SSEL, byte_valid, byte_data,
        output tx_byte, background_state, solid_color, audio_en, wr_strobe, wr_addr
    );
endinterface

// File: rtl/spi_cfg_regs_regfile.sv
// spi_cfg_regs_regfile: writable config registers, read mux and status counters
module spi_cfg_regs_regfile
    import spi_cfg_regs_pkg::*;
#(
    parameter int         ADDR_W   = 4,
    parameter logic [7:0] BG_RESET = 8'd10
) (
    input  logic              SCLK,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic              i_cmd_ok,
    input  logic              i_cmd_err,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata,
    output logic [7:0]        o_bg,
    output logic [5:0]        o_color,
    output logic              o_audio,
    output logic              o_wr_strobe,
    output logic [ADDR_W-1:0] o_wr_addr
);
    logic [7:0]        r_bg;
    logic [5:0]        r_color;
    logic              r_audio;
    logic [7:0]        r_scratch;
    logic [3:0]        r_err;
    logic [3:0]        r_frame;
    logic              r_wr_strobe;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              w_wr_ok;

    assign w_wr_ok     = i_we && i_waddr <= REG_SCRATCH;
    assign o_bg        = r_bg;
    assign o_color     = r_color;
    assign o_audio     = r_audio;
    assign o_wr_strobe = r_wr_strobe;
    assign o_wr_addr   = r_wr_addr;

    // Commit a write to the backing register; only addresses 0-3 are writable and strobe
    always_ff @(posedge SCLK) begin
        if (!rst_n) begin
            r_bg        <= BG_RESET;
            r_color     <= '0;
            r_audio     <= 1'b0;
            r_scratch   <= '0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
        end else begin
            if (w_wr_ok && i_waddr == REG_BG)      r_bg      <= i_wdata;
            if (w_wr_ok && i_waddr == REG_COLOR)   r_color   <= i_wdata[5:0];
            if (w_wr_ok && i_waddr == REG_AUDIO)   r_audio   <= i_wdata[0];
            if (w_wr_ok && i_waddr == REG_SCRATCH) r_scratch <= i_wdata;
            r_wr_strobe <= w_wr_ok;
            if (w_wr_ok) r_wr_addr <= i_waddr;
        end
    end

    // Frame counter wraps, error counter saturates
    always_ff @(posedge SCLK) begin
        if (!rst_n) begin
            r_err   <= '0;
            r_frame <= '0;
        end else begin
            if (i_cmd_ok) r_frame <= r_frame + 4'd1;
            if (i_cmd_err && r_err != 4'hF) r_err <= r_err + 4'd1;
        end
    end

    // Read mux with zero-fill for narrow and reserved registers
    always_comb begin
        o_rdata = i_raddr == REG_BG      ? r_bg :
                  i_raddr == REG_COLOR   ? {2'b00, r_color} :
                  i_raddr == REG_AUDIO   ? {7'b0, r_audio} :
                  i_raddr == REG_SCRATCH ? r_scratch :
                  i_raddr == REG_STATUS  ? {r_err, r_frame} : 8'h00;
    end
endmodule

// File: rtl/spi_cfg_regs.sv
// spi_cfg_regs: frames the SPI byte stream into register transactions
module spi_cfg_regs
    import spi_cfg_regs_pkg::*;
#(
    parameter int         ADDR_W   = 4,
    parameter logic [7:0] BG_RESET = 8'd10
) (
    input  logic         SCLK,
    input  logic         rst_n,
    spi_cfg_regs_if.slave io_bus
);
    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [7:0]        r_tx;
    logic              r_wr_pend;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              w_cmd_ok, w_cmd_err, w_wr_req;
    logic [7:0]        w_rdata;

    // Next state and address; deselect aborts the frame and wins over a byte
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cmd_ok    = 1'b0;
        w_cmd_err   = 1'b0;
        w_wr_req    = 1'b0;
        if (io_bus.SSEL) begin
            w_state_nxt = ST_IDLE;
            w_addr_nxt  = '0;
        end else if (io_bus.byte_valid) begin
            case (r_state)
                ST_IDLE: begin
                    w_cmd_err   = cmd_bad(io_bus.byte_data);
                    w_cmd_ok    = !w_cmd_err;
                    w_state_nxt = w_cmd_err ? ST_ERR :
                                  io_bus.byte_data[CMD_RD_BIT] ? ST_READ : ST_WRITE;
                    w_addr_nxt  = w_cmd_err ? r_addr : io_bus.byte_data[ADDR_W-1:0];
                end
                ST_WRITE: begin
                    w_wr_req   = 1'b1;
                    w_addr_nxt = r_addr + ADDR_W'(1);
                end
                ST_READ:  w_addr_nxt = r_addr + ADDR_W'(1);
                default:  w_state_nxt = ST_ERR;
            endcase
        end
    end

    // State, address, pipelined write request and prefetched read-back byte
    always_ff @(posedge SCLK) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_tx      <= 8'h00;
            r_wr_pend <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_tx      <= (r_state == ST_READ && w_state_nxt == ST_READ) ? w_rdata : 8'h00;
            r_wr_pend <= w_wr_req;
            r_wr_addr <= r_addr;
            r_wr_data <= io_bus.byte_data;
        end
    end

    assign io_bus.tx_byte = r_tx;

    spi_cfg_regs_regfile #(.ADDR_W(ADDR_W), .BG_RESET(BG_RESET)) u_regfile (
        .SCLK        (SCLK),
        .rst_n       (rst_n),
        .i_we        (r_wr_pend),
        .i_waddr     (r_wr_addr),
        .i_wdata     (r_wr_data),
        .i_cmd_ok    (w_cmd_ok),
        .i_cmd_err   (w_cmd_err),
        .i_raddr     (r_addr),
        .o_rdata     (w_rdata),
        .o_bg        (io_bus.background_state),
        .o_color     (io_bus.solid_color),
        .o_audio     (io_bus.audio_en),
        .o_wr_strobe (io_bus.wr_strobe),
        .o_wr_addr   (io_bus.wr_addr)
    );
endmodule

// File: tb/tb_spi_cfg_regs.sv
// tb_spi_cfg_regs: directed plus random frames against a register-map model
module tb_spi_cfg_regs;
    logic SCLK = 1'b0;
    logic rst_n = 1'b0;
    spi_cfg_regs_if #(.ADDR_W(4)) bus ();
    spi_cfg_regs #(.ADDR_W(4), .BG_RESET(8'd10)) dut (.SCLK(SCLK), .rst_n(rst_n), .io_bus(bus));

    always #5 SCLK = ~SCLK;

    int total = 0;
    int bad = 0;
    logic [7:0] m_bg, m_scratch;
    logic [5:0] m_color;
    logic       m_audio;
    int         m_err, m_frame, m_mode, m_addr;
    logic [3:0] m_wr_addr;

    function automatic logic [7:0] m_read(input int a);
        case (a)
            0: return m_bg;
            1: return {2'b00, m_color};
            2: return {7'b0, m_audio};
            3: return m_scratch;
            15: return {4'(m_err), 4'(m_frame)};
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic stb);
        check({tag, ".bg"}, bus.background_state, m_bg);
        check({tag, ".color"}, bus.solid_color, m_color);
        check({tag, ".audio"}, bus.audio_en, m_audio);
        check({tag, ".strobe"}, bus.wr_strobe, stb);
        check({tag, ".wr_addr"}, bus.wr_addr, m_wr_addr);
        check({tag, ".tx"}, bus.tx_byte, m_mode == 2 ? m_read(m_addr) : 8'h00);
    endtask

    task automatic m_reset();
        m_bg = 8'd10; m_color = '0; m_audio = 0; m_scratch = 0;
        m_err = 0; m_frame = 0; m_mode = 0; m_addr = 0; m_wr_addr = 0;
    endtask

    // mode: 0 expecting command, 1 write, 2 read, 3 error
    task automatic m_byte(input logic [7:0] b, output logic stb);
        stb = 0;
        if (m_mode == 0) begin
            if (b[6:4] != 0) begin
                m_mode = 3;
                if (m_err < 15) m_err++;
            end else begin
                m_mode = b[7] ? 2 : 1;
                m_addr = b[3:0];
                m_frame = (m_frame + 1) % 16;
            end
        end else if (m_mode == 1) begin
            if (m_addr <= 3) begin
                stb = 1;
                m_wr_addr = 4'(m_addr);
                if (m_addr == 0) m_bg = b;
                if (m_addr == 1) m_color = b[5:0];
                if (m_addr == 2) m_audio = b[0];
                if (m_addr == 3) m_scratch = b;
            end
            m_addr = (m_addr + 1) % 16;
        end else if (m_mode == 2) begin
            m_addr = (m_addr + 1) % 16;
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic stb;
        m_byte(b, stb);
        bus.byte_data = b;
        bus.byte_valid = 1;
        @(posedge SCLK); #1 bus.byte_valid = 0;
        @(posedge SCLK); #1 check_outs("byte", stb);
        @(posedge SCLK); #1 check("strobe_low", bus.wr_strobe, 1'b0);
        repeat (5) @(posedge SCLK);
        #1;
    endtask

    task automatic end_frame();
        bus.SSEL = 1;
        @(posedge SCLK); #1 bus.SSEL = 0;
        m_mode = 0;
        m_addr = 0;
        check_outs("ssel", 1'b0);
    endtask

    initial begin
        logic stb;
        m_reset();
        bus.SSEL = 1;
        bus.byte_valid = 0;
        bus.byte_data = 0;
        rst_n = 0;
        repeat (3) @(posedge SCLK);
        #1 check_outs("reset", 1'b0);
        rst_n = 1;
        @(posedge SCLK); #1 bus.SSEL = 0;

        send(8'h00); send(8'h2A); send(8'h15); send(8'h01);
        end_frame();
        check("plan1.bg", bus.background_state, 8'h2A);
        check("plan1.color", bus.solid_color, 6'h15);
        check("plan1.audio", bus.audio_en, 1'b1);

        send(8'h30); send(8'hFF); send(8'hFF);
        end_frame();
        check("err.bg", bus.background_state, 8'h2A);
        send(8'h8F);
        check("status", bus.tx_byte, 8'h12);
        send(8'h00);
        check("read_reg0", bus.tx_byte, 8'h2A);
        end_frame();

        send(8'h0F); send(8'hAA); send(8'h55);
        check("wrap.bg", bus.background_state, 8'h55);
        check("wrap.wr_addr", bus.wr_addr, 4'd0);
        end_frame();

        send(8'h03); send(8'h77);
        end_frame();
        send(8'h83);
        check("scratch", bus.tx_byte, 8'h77);
        end_frame();

        send(8'h00); send(8'h11);
        end_frame();
        check("abort.bg", bus.background_state, 8'h11);
        check("abort.color", bus.solid_color, 6'h15);
        send(8'h81);
        check("abort.idle", bus.tx_byte, 8'h15);
        end_frame();

        send(8'h01);
        bus.byte_data = 8'h3F;
        bus.byte_valid = 1;
        bus.SSEL = 1;
        @(posedge SCLK); #1 bus.byte_valid = 0;
        bus.SSEL = 0;
        m_mode = 0;
        m_addr = 0;
        @(posedge SCLK); #1 check_outs("collide", 1'b0);

        send(8'h02);
        bus.byte_data = 8'hA1;
        bus.byte_valid = 1;
        m_byte(8'hA1, stb);
        @(posedge SCLK); #1 bus.byte_data = 8'hB2;
        m_byte(8'hB2, stb);
        @(posedge SCLK); #1 bus.byte_valid = 0;
        @(posedge SCLK); #1 check_outs("b2b", 1'b1);
        check("b2b.wr_addr", bus.wr_addr, 4'd3);
        end_frame();

        send(8'h80); send(8'h00);
        rst_n = 0;
        @(posedge SCLK); #1 rst_n = 1;
        m_reset();
        check_outs("rst_mid", 1'b0);
        check("rst_mid.bg10", bus.background_state, 8'd10);
        send(8'h00); send(8'h33);
        check("rst_cmd.bg", bus.background_state, 8'h33);
        end_frame();

        for (int i = 0; i < 40; i++) begin
            logic [2:0] rsvd;
            int n;
            rsvd = (i < 16 || $urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            send({1'($urandom_range(0, 1)), rsvd, 4'($urandom_range(0, 15))});
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) send(8'($urandom));
            end_frame();
        end
        send(8'h8F);
        check("err_sat", bus.tx_byte[7:4], 4'hF);
        end_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
